fpnew_result_buffer: RTL and testbench



---
 rtl/fpnew_pkg.sv | 13 +
 rtl/fpnew_result_fifo.sv | 54 +++++
 rtl/fpnew_result_buffer.sv | 82 ++++++++
 tb/tb_fpnew_result_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPU types used by the result buffer.
// Status flag order matches the RISC-V fflags CSR.
package fpnew_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

endpackage

// File: rtl/fpnew_result_fifo.sv
// Generic storage FIFO with exact full/empty via a count register.
// No bypass: a pushed entry becomes visible on the next cycle.
module fpnew_result_fifo #(
    parameter int unsigned Depth   = 4,
    parameter type         entry_t = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  entry_t                     in_data_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output entry_t                     out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [$clog2(Depth+1)-1:0] usage_o
);

    localparam int unsigned AddrWidth  = $clog2(Depth);
    localparam int unsigned UsageWidth = $clog2(Depth+1);

    entry_t                  mem_q [Depth];
    logic [AddrWidth-1:0]    wr_ptr_q;
    logic [AddrWidth-1:0]    rd_ptr_q;
    logic [UsageWidth-1:0]   count_q;
    logic                    push;
    logic                    pop;

    assign in_ready_o  = (count_q != UsageWidth'(Depth));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign usage_o     = count_q;

    // Pointer and occupancy bookkeeping; flush empties like reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
            count_q <= count_q + UsageWidth'(push) - UsageWidth'(pop);
        end
    end

    // Entry storage is left unreset; contents are only read while valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/fpnew_result_buffer.sv
// FPU output buffer: decouples writeback stalls from the FPU and
// accrues sticky fflags from every retired result.
module fpnew_result_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned Width   = 64,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic [Width-1:0]           in_result_i,
    input  status_t                    in_status_i,
    input  TagType                     in_tag_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [Width-1:0]           out_result_o,
    output status_t                    out_status_o,
    output TagType                     out_tag_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    input  logic                       fflags_clr_i,
    output logic [4:0]                 fflags_o,
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       busy_o
);

    localparam int unsigned UsageWidth = $clog2(Depth+1);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        TagType           tag;
    } entry_t;

    entry_t                in_entry;
    entry_t                out_entry;
    logic                  pop;
    logic [4:0]            pop_flags;
    logic [4:0]            fflags_q;
    logic [UsageWidth-1:0] usage;

    assign in_entry = '{result: in_result_i, status: in_status_i, tag: in_tag_i};

    fpnew_result_fifo #(
        .Depth   (Depth),
        .entry_t (entry_t)
    ) i_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_data_i   (in_entry),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_entry),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .usage_o     (usage)
    );

    assign out_result_o = out_entry.result;
    assign out_status_o = out_entry.status;
    assign out_tag_o    = out_entry.tag;
    assign usage_o      = usage;
    assign busy_o       = (usage != '0);

    assign pop       = out_valid_o & out_ready_i & ~flush_i;
    assign pop_flags = pop ? out_entry.status : 5'b0;

    // Sticky flags: cleared on request, then OR in the retiring status.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q) | pop_flags;
        end
    end

    assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Self-checking bench for fpnew_result_buffer.
// Reference model is a plain queue plus a sticky-flag word.
module tb_fpnew_result_buffer;
    import fpnew_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] r;
        logic [4:0]  s;
        logic [3:0]  t;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic [63:0] in_result_i = '0;
    status_t     in_status_i = '0;
    logic [3:0]  in_tag_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [63:0] out_result_o;
    status_t     out_status_o;
    logic [3:0]  out_tag_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic        fflags_clr_i = 1'b0;
    logic [4:0]  fflags_o;
    logic [2:0]  usage_o;
    logic        busy_o;

    int    checks = 0;
    int    errors = 0;
    beat_t q[$];
    logic [4:0] m_flags = '0;

    always #5 clk = ~clk;

    fpnew_result_buffer #(
        .Width   (64),
        .Depth   (DEPTH),
        .TagType (logic [3:0])
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .in_result_i  (in_result_i),
        .in_status_i  (in_status_i),
        .in_tag_i     (in_tag_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .out_result_o (out_result_o),
        .out_status_o (out_status_o),
        .out_tag_o    (out_tag_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .fflags_clr_i (fflags_clr_i),
        .fflags_o     (fflags_o),
        .usage_o      (usage_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] t,
                         input logic [4:0] s, input logic [63:0] r);
        in_valid_i  = v;
        in_tag_i    = t;
        in_status_i = s;
        in_result_i = r;
    endtask

    // Compare DUT against the model, advance the model, then one clock.
    task automatic step(input bit do_chk = 1'b1);
        bit push, pop;
        if (do_chk) begin
            chk("out_valid", out_valid_o, q.size() != 0);
            chk("in_ready", in_ready_o, q.size() != DEPTH);
            chk("usage", usage_o, q.size());
            chk("busy", busy_o, q.size() != 0);
            chk("fflags", fflags_o, m_flags);
            if (q.size() != 0) begin
                chk("result", out_result_o, q[0].r);
                chk("status", out_status_o, q[0].s);
                chk("tag", out_tag_o, q[0].t);
            end
        end
        if (!rst_ni) begin
            q.delete();
            m_flags = '0;
        end else begin
            pop  = (q.size() != 0) && out_ready_i && !flush_i;
            push = in_valid_i && (q.size() != DEPTH) && !flush_i;
            m_flags = (fflags_clr_i ? 5'b0 : m_flags) | (pop ? q[0].s : 5'b0);
            if (flush_i) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{in_result_i, in_status_i, in_tag_i});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        step(1'b0);
        step(1'b0);
        rst_ni = 1'b1;
        chk("reset_valid", out_valid_o, 1'b0);
        chk("reset_ready", in_ready_o, 1'b1);
        chk("reset_flags", fflags_o, 5'b0);

        // Single beat with writeback ready.
        out_ready_i = 1'b1;
        drive(1'b1, 4'd1, 5'b00001, 64'h3FF0_0000_0000_0000);
        step();
        drive(1'b0, 4'd0, 5'b0, 64'h0);
        chk("beat_valid", out_valid_o, 1'b1);
        chk("beat_result", out_result_o, 64'h3FF0_0000_0000_0000);
        step();
        chk("beat_flags", fflags_o, 5'b00001);
        chk("beat_usage", usage_o, 3'd0);

        // Fill with writeback stalled.
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i), 5'b0, 64'(i) + 64'h100);
            step();
        end
        chk("fill_ready", in_ready_o, 1'b0);
        chk("fill_usage", usage_o, 3'd4);
        drive(1'b1, 4'd4, 5'b0, 64'h104);
        step();
        step();
        chk("held_usage", usage_o, 3'd4);

        // Full with pop and push together: only the pop happens.
        out_ready_i = 1'b1;
        step();
        chk("full_sim_usage", usage_o, 3'd3);
        step();
        chk("after_sim_usage", usage_o, 3'd3);
        drive(1'b0, 4'd0, 5'b0, 64'h0);
        for (int i = 0; i < 4; i++) step();
        chk("drained", out_valid_o, 1'b0);

        // Stream across the pointer wrap at occupancy 2.
        out_ready_i = 1'b0;
        drive(1'b1, 4'd14, 5'b0, 64'hE);
        step();
        drive(1'b1, 4'd15, 5'b0, 64'hF);
        step();
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'(i), 5'b0, 64'(i) << 8);
            step();
        end
        chk("wrap_usage", usage_o, 3'd2);
        drive(1'b0, 4'd0, 5'b0, 64'h0);
        step();
        step();

        // Flag accrual and clear-with-pop.
        out_ready_i = 1'b0;
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        drive(1'b1, 4'd1, 5'b10000, 64'h1);
        step();
        drive(1'b1, 4'd2, 5'b00100, 64'h2);
        step();
        drive(1'b0, 4'd0, 5'b0, 64'h0);
        out_ready_i = 1'b1;
        step();
        step();
        chk("flags_or", fflags_o, 5'b10100);
        out_ready_i = 1'b0;
        drive(1'b1, 4'd3, 5'b00010, 64'h3);
        step();
        drive(1'b0, 4'd0, 5'b0, 64'h0);
        out_ready_i = 1'b1;
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        chk("flags_clr_pop", fflags_o, 5'b00010);

        // Flush with a push in the same cycle, then reset.
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i), 5'b01000, 64'(i));
            step();
        end
        flush_i = 1'b1;
        out_ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        drive(1'b0, 4'd0, 5'b0, 64'h0);
        chk("flush_usage", usage_o, 3'd0);
        chk("flush_valid", out_valid_o, 1'b0);
        chk("flush_flags", fflags_o, 5'b00010);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("rst_flags", fflags_o, 5'b0);
        chk("rst_busy", busy_o, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 2) != 0, 4'($urandom),
                  5'($urandom), {$urandom, $urandom});
            out_ready_i  = $urandom_range(0, 2) == 0;
            flush_i      = $urandom_range(0, 40) == 0;
            fflags_clr_i = $urandom_range(0, 15) == 0;
            rst_ni       = $urandom_range(0, 300) != 0;
            step();
        end
        rst_ni = 1'b1;
        flush_i = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
